rs_complex: RTL and testbench

Two-entry reservation station for the complex execution pipe. It accepts one dispatched instruction per cycle and holds up to two instructions. It captures missing source operands from the two writeback buses and presents both entries, with ROB tags and an age selector, to the complex execute stage. That stage picks a ready entry combinationally and returns a per-entry issue pulse, which frees the entry.

---
 rtl/rs_complex.sv | 147 ++++++++++++++
 tb/tb_rs_complex.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_complex.sv
// rs_complex: two-entry reservation station feeding the complex execute pipe.
// Holds up to two dispatched instructions, snoops both writeback buses to
// capture missing source operands, and frees an entry when execute issues it.
module rs_complex (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         disp_valid,
  input  logic [113:0] disp_inst,
  input  logic [3:0]   disp_rob_num,
  output logic         disp_ready,
  input  logic         wb0_valid,
  input  logic [3:0]   wb0_rob_num,
  input  logic [31:0]  wb0_data,
  input  logic         wb1_valid,
  input  logic [3:0]   wb1_rob_num,
  input  logic [31:0]  wb1_data,
  output logic [113:0] rs_complex_0,
  output logic [113:0] rs_complex_1,
  output logic [3:0]   rs_complex_0_entry_num,
  output logic [3:0]   rs_complex_1_entry_num,
  output logic         selector,
  input  logic         complex_0_issue,
  input  logic         complex_1_issue,
  output logic [1:0]   occupancy
);

  logic [1:0]   valid_q, valid_d;
  logic [113:0] payload_q [2];
  logic [113:0] payload_d [2];
  logic [3:0]   tag_q [2];
  logic [3:0]   tag_d [2];
  logic         selector_q, selector_d;

  logic         accept;
  logic         target;
  logic [1:0]   issue;
  logic [113:0] disp_woken;

  // Apply both writeback buses to one payload; a not-ready operand keeps its
  // producer tag in the low nibble of its field, and wb0 wins a double match.
  function automatic logic [113:0] wake(
    input logic [113:0] p,
    input logic         w0v,
    input logic [3:0]   w0t,
    input logic [31:0]  w0d,
    input logic         w1v,
    input logic [3:0]   w1t,
    input logic [31:0]  w1d
  );
    logic [113:0] r;
    r = p;
    if (!p[5]) begin
      if (w0v && (w0t == p[9:6])) begin
        r[37:6] = w0d;
        r[5]    = 1'b1;
      end else if (w1v && (w1t == p[9:6])) begin
        r[37:6] = w1d;
        r[5]    = 1'b1;
      end
    end
    if (!p[38]) begin
      if (w0v && (w0t == p[42:39])) begin
        r[70:39] = w0d;
        r[38]    = 1'b1;
      end else if (w1v && (w1t == p[42:39])) begin
        r[70:39] = w1d;
        r[38]    = 1'b1;
      end
    end
    return r;
  endfunction

  // Hide the ready bits of an empty entry so execute never picks it.
  function automatic logic [113:0] mask_ready(input logic [113:0] p, input logic v);
    logic [113:0] r;
    r     = p;
    r[5]  = p[5] & v;
    r[38] = p[38] & v;
    return r;
  endfunction

  assign issue      = {complex_1_issue, complex_0_issue};
  assign disp_ready = ~(valid_q[0] & valid_q[1]);
  assign accept     = disp_valid & disp_ready;
  // Lowest free entry: entry 1 only when entry 0 is occupied.
  assign target     = valid_q[0];
  assign disp_woken = wake(disp_inst, wb0_valid, wb0_rob_num, wb0_data,
                           wb1_valid, wb1_rob_num, wb1_data);

  // Next-state: flush beats everything, issue beats wakeup, then dispatch fills a free slot.
  always_comb begin
    valid_d    = valid_q;
    selector_d = selector_q;
    for (int k = 0; k < 2; k++) begin
      payload_d[k] = payload_q[k];
      tag_d[k]     = tag_q[k];
    end
    if (flush) begin
      valid_d = 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (valid_q[k]) begin
          if (issue[k]) begin
            valid_d[k] = 1'b0;
          end else begin
            payload_d[k] = wake(payload_q[k], wb0_valid, wb0_rob_num, wb0_data,
                                wb1_valid, wb1_rob_num, wb1_data);
          end
        end
      end
      if (accept) begin
        valid_d[target]   = 1'b1;
        payload_d[target] = disp_woken;
        tag_d[target]     = disp_rob_num;
        selector_d        = target;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 2'b00;
      selector_q   <= 1'b0;
      payload_q[0] <= '0;
      payload_q[1] <= '0;
      tag_q[0]     <= '0;
      tag_q[1]     <= '0;
    end else begin
      valid_q      <= valid_d;
      selector_q   <= selector_d;
      payload_q[0] <= payload_d[0];
      payload_q[1] <= payload_d[1];
      tag_q[0]     <= tag_d[0];
      tag_q[1]     <= tag_d[1];
    end
  end

  assign rs_complex_0           = mask_ready(payload_q[0], valid_q[0]);
  assign rs_complex_1           = mask_ready(payload_q[1], valid_q[1]);
  assign rs_complex_0_entry_num = tag_q[0];
  assign rs_complex_1_entry_num = tag_q[1];
  assign selector               = selector_q;
  assign occupancy              = {1'b0, valid_q[0]} + {1'b0, valid_q[1]};

endmodule

// File: tb/tb_rs_complex.sv
// Testbench for rs_complex: a table of per-cycle stimulus records with the
// expected post-edge state, checked through an expectation queue, followed by
// a few hand-written sequences for reset and output-path independence.
module tb_rs_complex;

  typedef struct {
    logic [113:0] e0;
    logic [113:0] e1;
    logic [3:0]   n0;
    logic [3:0]   n1;
    logic         sel;
    logic [1:0]   occ;
    logic         drdy;
  } exp_t;

  typedef struct {
    logic         flush;
    logic         dv;
    logic [113:0] inst;
    logic [3:0]   rob;
    logic         w0v;
    logic [3:0]   w0t;
    logic [31:0]  w0d;
    logic         w1v;
    logic [3:0]   w1t;
    logic [31:0]  w1d;
    logic         i0;
    logic         i1;
    exp_t         x;
  } vec_t;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         disp_valid;
  logic [113:0] disp_inst;
  logic [3:0]   disp_rob_num;
  logic         disp_ready;
  logic         wb0_valid;
  logic [3:0]   wb0_rob_num;
  logic [31:0]  wb0_data;
  logic         wb1_valid;
  logic [3:0]   wb1_rob_num;
  logic [31:0]  wb1_data;
  logic [113:0] rs_complex_0;
  logic [113:0] rs_complex_1;
  logic [3:0]   rs_complex_0_entry_num;
  logic [3:0]   rs_complex_1_entry_num;
  logic         selector;
  logic         complex_0_issue;
  logic         complex_1_issue;
  logic [1:0]   occupancy;

  int   applied = 0;
  int   miscompares = 0;
  int   stepId = 0;
  exp_t sbq[$];
  vec_t tbl[$];

  rs_complex dut (
    .clk                    (clk),
    .rst                    (rst),
    .flush                  (flush),
    .disp_valid             (disp_valid),
    .disp_inst              (disp_inst),
    .disp_rob_num           (disp_rob_num),
    .disp_ready             (disp_ready),
    .wb0_valid              (wb0_valid),
    .wb0_rob_num            (wb0_rob_num),
    .wb0_data               (wb0_data),
    .wb1_valid              (wb1_valid),
    .wb1_rob_num            (wb1_rob_num),
    .wb1_data               (wb1_data),
    .rs_complex_0           (rs_complex_0),
    .rs_complex_1           (rs_complex_1),
    .rs_complex_0_entry_num (rs_complex_0_entry_num),
    .rs_complex_1_entry_num (rs_complex_1_entry_num),
    .selector               (selector),
    .complex_0_issue        (complex_0_issue),
    .complex_1_issue        (complex_1_issue),
    .occupancy              (occupancy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build an entry word; the control fields are fixed so any corruption of them shows up.
  function automatic logic [113:0] mk(input logic [31:0] o1, input logic r1,
                                      input logic [31:0] o2, input logic r2,
                                      input logic [4:0] wr);
    return {32'hA5A50000 | {27'd0, wr}, 6'h2A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
            o2, r2, o1, r1, wr};
  endfunction

  function automatic exp_t ex(input logic [113:0] e0, input logic [113:0] e1,
                              input logic [3:0] n0, input logic [3:0] n1,
                              input logic sel, input logic [1:0] occ, input logic drdy);
    exp_t x;
    x.e0 = e0; x.e1 = e1; x.n0 = n0; x.n1 = n1;
    x.sel = sel; x.occ = occ; x.drdy = drdy;
    return x;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v.flush = 1'b0; v.dv = 1'b0; v.inst = '0; v.rob = '0;
    v.w0v = 1'b0; v.w0t = '0; v.w0d = '0;
    v.w1v = 1'b0; v.w1t = '0; v.w1d = '0;
    v.i0 = 1'b0; v.i1 = 1'b0;
    v.x = ex('0, '0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b1);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    flush           = v.flush;
    disp_valid      = v.dv;
    disp_inst       = v.inst;
    disp_rob_num    = v.rob;
    wb0_valid       = v.w0v;
    wb0_rob_num     = v.w0t;
    wb0_data        = v.w0d;
    wb1_valid       = v.w1v;
    wb1_rob_num     = v.w1t;
    wb1_data        = v.w1d;
    complex_0_issue = v.i0;
    complex_1_issue = v.i1;
    sbq.push_back(v.x);
  endtask

  task automatic cmp(input string nm, input logic [113:0] act, input logic [113:0] want);
    applied++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL step %0d %s: got %h expected %h", stepId, nm, act, want);
    end
  endtask

  task automatic checkOutput();
    exp_t x;
    if (sbq.size() == 0) begin
      applied++;
      miscompares++;
      $display("[TB] FAIL step %0d scoreboard: got empty queue expected an entry", stepId);
    end else begin
      x = sbq.pop_front();
      cmp("rs_complex_0", rs_complex_0, x.e0);
      cmp("rs_complex_1", rs_complex_1, x.e1);
      cmp("entry_num_0", {110'd0, rs_complex_0_entry_num}, {110'd0, x.n0});
      cmp("entry_num_1", {110'd0, rs_complex_1_entry_num}, {110'd0, x.n1});
      cmp("selector", {113'd0, selector}, {113'd0, x.sel});
      cmp("occupancy", {112'd0, occupancy}, {112'd0, x.occ});
      cmp("disp_ready", {113'd0, disp_ready}, {113'd0, x.drdy});
    end
    stepId++;
  endtask

  initial begin
    vec_t v;
    logic [113:0] eAB;
    eAB = mk(32'hAAAA0000, Y, 32'hBBBB0000, Y, 5'd11);

    // Step 0: dispatch tag 3 with both operands ready.
    v = idle(); v.dv = 1'b1; v.inst = mk(32'h5, Y, 32'h7, Y, 5'd3); v.rob = 4'd3;
    v.x = ex(mk(32'h5, Y, 32'h7, Y, 5'd3), '0, 4'd3, 4'd0, 1'b0, 2'd1, 1'b1); tbl.push_back(v);
    // Issue it so the station is empty again; payload stays with ready bits hidden.
    v = idle(); v.i0 = 1'b1;
    v.x = ex(mk(32'h5, N, 32'h7, N, 5'd3), '0, 4'd3, 4'd0, 1'b0, 2'd0, 1'b1); tbl.push_back(v);
    // Fill: tag 1 then tag 2.
    v = idle(); v.dv = 1'b1; v.inst = mk(32'h11, Y, 32'h12, Y, 5'd1); v.rob = 4'd1;
    v.x = ex(mk(32'h11, Y, 32'h12, Y, 5'd1), '0, 4'd1, 4'd0, 1'b0, 2'd1, 1'b1); tbl.push_back(v);
    v = idle(); v.dv = 1'b1; v.inst = mk(32'h21, Y, 32'h22, Y, 5'd2); v.rob = 4'd2;
    v.x = ex(mk(32'h11, Y, 32'h12, Y, 5'd1), mk(32'h21, Y, 32'h22, Y, 5'd2), 4'd1, 4'd2, 1'b1, 2'd2, 1'b0); tbl.push_back(v);
    // Dispatch while full is dropped.
    v = idle(); v.dv = 1'b1; v.inst = mk(32'h31, Y, 32'h32, Y, 5'd5); v.rob = 4'd5;
    v.x = ex(mk(32'h11, Y, 32'h12, Y, 5'd1), mk(32'h21, Y, 32'h22, Y, 5'd2), 4'd1, 4'd2, 1'b1, 2'd2, 1'b0); tbl.push_back(v);
    // Issue both entries at once.
    v = idle(); v.i0 = 1'b1; v.i1 = 1'b1;
    v.x = ex(mk(32'h11, N, 32'h12, N, 5'd1), mk(32'h21, N, 32'h22, N, 5'd2), 4'd1, 4'd2, 1'b1, 2'd0, 1'b1); tbl.push_back(v);
    // Dispatch tag 4 with rs1 waiting on tag 9.
    v = idle(); v.dv = 1'b1; v.inst = mk(32'h9, N, 32'h44, Y, 5'd4); v.rob = 4'd4;
    v.x = ex(mk(32'h9, N, 32'h44, Y, 5'd4), mk(32'h21, N, 32'h22, N, 5'd2), 4'd4, 4'd2, 1'b0, 2'd1, 1'b1); tbl.push_back(v);
    // wb1 wakes rs1; wb0 carries an unrelated tag.
    v = idle(); v.w1v = 1'b1; v.w1t = 4'd9; v.w1d = 32'hDEADBEEF; v.w0v = 1'b1; v.w0t = 4'd7; v.w0d = 32'h77;
    v.x = ex(mk(32'hDEADBEEF, Y, 32'h44, Y, 5'd4), mk(32'h21, N, 32'h22, N, 5'd2), 4'd4, 4'd2, 1'b0, 2'd1, 1'b1); tbl.push_back(v);
    // Dispatch bypass: rs2 waits on tag 6 while wb0 broadcasts tag 6.
    v = idle(); v.dv = 1'b1; v.inst = mk(32'h51, Y, 32'h6, N, 5'd5); v.rob = 4'd5; v.w0v = 1'b1; v.w0t = 4'd6; v.w0d = 32'h1234;
    v.x = ex(mk(32'hDEADBEEF, Y, 32'h44, Y, 5'd4), mk(32'h51, Y, 32'h1234, Y, 5'd5), 4'd4, 4'd5, 1'b1, 2'd2, 1'b0); tbl.push_back(v);
    // Issue entry 0 from a full station, then refill it with tag 8.
    v = idle(); v.i0 = 1'b1;
    v.x = ex(mk(32'hDEADBEEF, N, 32'h44, N, 5'd4), mk(32'h51, Y, 32'h1234, Y, 5'd5), 4'd4, 4'd5, 1'b1, 2'd1, 1'b1); tbl.push_back(v);
    v = idle(); v.dv = 1'b1; v.inst = mk(32'h81, Y, 32'h82, Y, 5'd8); v.rob = 4'd8;
    v.x = ex(mk(32'h81, Y, 32'h82, Y, 5'd8), mk(32'h51, Y, 32'h1234, Y, 5'd5), 4'd8, 4'd5, 1'b0, 2'd2, 1'b0); tbl.push_back(v);
    // Issue while full plus dispatch: no same-cycle bypass, dispatch dropped.
    v = idle(); v.i1 = 1'b1; v.dv = 1'b1; v.inst = mk(32'hA1, Y, 32'hA2, Y, 5'd10); v.rob = 4'd10;
    v.x = ex(mk(32'h81, Y, 32'h82, Y, 5'd8), mk(32'h51, N, 32'h1234, N, 5'd5), 4'd8, 4'd5, 1'b0, 2'd1, 1'b1); tbl.push_back(v);
    // Issue entry 0 while dispatching into the other free entry.
    v = idle(); v.i0 = 1'b1; v.dv = 1'b1; v.inst = mk(32'h2, N, 32'h3, N, 5'd11); v.rob = 4'd11;
    v.x = ex(mk(32'h81, N, 32'h82, N, 5'd8), mk(32'h2, N, 32'h3, N, 5'd11), 4'd8, 4'd11, 1'b1, 2'd1, 1'b1); tbl.push_back(v);
    // Both operands wake from different buses in one cycle.
    v = idle(); v.w0v = 1'b1; v.w0t = 4'd2; v.w0d = 32'hAAAA0000; v.w1v = 1'b1; v.w1t = 4'd3; v.w1d = 32'hBBBB0000;
    v.x = ex(mk(32'h81, N, 32'h82, N, 5'd8), eAB, 4'd8, 4'd11, 1'b1, 2'd1, 1'b1); tbl.push_back(v);
    // Both buses match both operands at dispatch: wb0 wins.
    v = idle(); v.dv = 1'b1; v.inst = mk(32'h7, N, 32'h7, N, 5'd12); v.rob = 4'd12;
    v.w0v = 1'b1; v.w0t = 4'd7; v.w0d = 32'h70; v.w1v = 1'b1; v.w1t = 4'd7; v.w1d = 32'h71;
    v.x = ex(mk(32'h70, Y, 32'h70, Y, 5'd12), eAB, 4'd12, 4'd11, 1'b0, 2'd2, 1'b0); tbl.push_back(v);
    v = idle(); v.i0 = 1'b1;
    v.x = ex(mk(32'h70, N, 32'h70, N, 5'd12), eAB, 4'd12, 4'd11, 1'b0, 2'd1, 1'b1); tbl.push_back(v);
    v = idle(); v.dv = 1'b1; v.inst = mk(32'h9, N, 32'h55, Y, 5'd13); v.rob = 4'd13;
    v.x = ex(mk(32'h9, N, 32'h55, Y, 5'd13), eAB, 4'd13, 4'd11, 1'b0, 2'd2, 1'b0); tbl.push_back(v);
    // Issue and wakeup on the same entry: the wakeup is discarded.
    v = idle(); v.i0 = 1'b1; v.w1v = 1'b1; v.w1t = 4'd9; v.w1d = 32'h99;
    v.x = ex(mk(32'h9, N, 32'h55, N, 5'd13), eAB, 4'd13, 4'd11, 1'b0, 2'd1, 1'b1); tbl.push_back(v);
    // Flush with dispatch and a matching writeback: everything empties, selector holds.
    v = idle(); v.flush = 1'b1; v.dv = 1'b1; v.inst = mk(32'h1, N, 32'h5, Y, 5'd14); v.rob = 4'd14;
    v.w0v = 1'b1; v.w0t = 4'd1; v.w0d = 32'h1111;
    v.x = ex(mk(32'h9, N, 32'h55, N, 5'd13), mk(32'hAAAA0000, N, 32'hBBBB0000, N, 5'd11), 4'd13, 4'd11, 1'b0, 2'd0, 1'b1); tbl.push_back(v);
    v = idle(); v.dv = 1'b1; v.inst = mk(32'hF1, Y, 32'hF2, Y, 5'd15); v.rob = 4'd15;
    v.x = ex(mk(32'hF1, Y, 32'hF2, Y, 5'd15), mk(32'hAAAA0000, N, 32'hBBBB0000, N, 5'd11), 4'd15, 4'd11, 1'b0, 2'd1, 1'b1); tbl.push_back(v);

    // Reset for two cycles and check the cleared state.
    rst = 1'b1;
    v = idle();
    applyStimulus(v);
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(posedge clk);
      #1;
      checkOutput();
    end

    // Issue and wakeup inputs must not reach the outputs before the edge.
    v = idle(); v.i0 = 1'b1; v.w0v = 1'b1; v.w0t = 4'd1; v.w0d = 32'h5555;
    v.x = ex(mk(32'hF1, Y, 32'hF2, Y, 5'd15), mk(32'hAAAA0000, N, 32'hBBBB0000, N, 5'd11), 4'd15, 4'd11, 1'b0, 2'd1, 1'b1);
    applyStimulus(v);
    #1;
    checkOutput();
    sbq.push_back(ex(mk(32'hF1, N, 32'hF2, N, 5'd15), mk(32'hAAAA0000, N, 32'hBBBB0000, N, 5'd11), 4'd15, 4'd11, 1'b0, 2'd0, 1'b1));
    @(posedge clk);
    #1;
    checkOutput();

    // Mid-run reset clears payloads and tags as well as valid bits.
    v = idle();
    applyStimulus(v);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
